// File: rtl/mpy_pkg.sv
// Shared types for the sequential signed multiplier family.
package mpy_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mpy_state_t;

endpackage

// File: rtl/mpy_addsub_s.sv
// Combinational W-bit adder/subtractor: y = sub ? p - q : p + q (modulo 2^W).
module mpy_addsub_s #(
  parameter int W = 16
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = sub ? (p - q) : (p + q);

endmodule

// File: rtl/mpy_seq_s.sv
// Sequential signed shift-and-add multiplier, one multiplier bit per clock,
// with valid/ready handshakes on operand and result sides.
module mpy_seq_s
  import mpy_pkg::*;
#(
  parameter  int WA = 8,
  parameter  int WB = 8,
  localparam int WY = WA + WB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WY-1:0] y,
  output logic          busy
);

  localparam int CW = (WB > 1) ? $clog2(WB) : 1;

  mpy_state_t    state_reg;
  logic [CW-1:0] count_reg;
  logic [WY-1:0] mcand_reg;
  logic [WB-1:0] mplr_reg;
  logic [WY-1:0] acc_reg;
  logic [WY-1:0] acc_next;
  logic [WY-1:0] addend;
  logic          out_valid_reg;
  logic          busy_reg;
  logic          last_bit;
  logic          load;

  // The final multiplier bit is the sign bit, so its partial product is subtracted.
  assign last_bit = (count_reg == CW'(WB - 1));
  assign addend   = mplr_reg[0] ? mcand_reg : '0;

  mpy_addsub_s #(.W(WY)) u_addsub (
    .p   (acc_reg),
    .q   (addend),
    .sub (last_bit),
    .y   (acc_next)
  );

  // DONE with out_ready lets a new operand pair in without an IDLE bubble.
  assign in_ready = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      mcand_reg     <= '0;
      mplr_reg      <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (load) begin
      state_reg     <= RUN;
      count_reg     <= '0;
      mcand_reg     <= {{WB{a[WA-1]}}, a};
      mplr_reg      <= b;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
          count_reg <= count_reg + 1'b1;
          if (last_bit) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        IDLE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y         = acc_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mpy_seq_s.sv
// Bench for mpy_seq_s: two instances (8x8 and 12x5) checked every cycle against
// a countdown/product model, plus literal products and latencies for directed ops.
module tb_mpy_seq_s;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_s [2];
  logic       out_ready_s [2];
  logic       ir_s [2];
  logic       ov_s [2];
  logic       bz_s [2];
  logic [7:0]  a0, b0;
  logic [11:0] a1;
  logic [4:0]  b1;
  logic [15:0] y0;
  logic [16:0] y1;
  logic signed [31:0] y_x [2];

  const int WBV [2] = '{8, 5};
  const int LAT [2] = '{9, 6};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int     m_left [2] = '{0, 0};
  bit     m_have [2] = '{1'b0, 1'b0};
  bit     m_ydef [2] = '{1'b1, 1'b1};
  longint m_y    [2] = '{0, 0};
  longint m_pend [2] = '{0, 0};
  int     acc_cyc [2] = '{0, 0};
  bit     acc_seen [2] = '{1'b0, 1'b0};
  bit     ov_prev [2] = '{1'b0, 1'b0};
  longint lit_q [$];

  always #5 clk = ~clk;

  mpy_seq_s #(.WA(8), .WB(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(ir_s[0]),
    .a(a0), .b(b0), .out_valid(ov_s[0]), .out_ready(out_ready_s[0]),
    .y(y0), .busy(bz_s[0])
  );

  mpy_seq_s #(.WA(12), .WB(5)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(ir_s[1]),
    .a(a1), .b(b1), .out_valid(ov_s[1]), .out_ready(out_ready_s[1]),
    .y(y1), .busy(bz_s[1])
  );

  assign y_x[0] = {{16{y0[15]}}, y0};
  assign y_x[1] = {{15{y1[16]}}, y1};

  function automatic longint prod(input int k);
    if (k == 0) return longint'($signed(a0)) * longint'($signed(b0));
    return longint'($signed(a1)) * longint'($signed(b1));
  endfunction

  function automatic bit exp_ready(input int k);
    return (m_left[k] == 0 && !m_have[k]) || (m_have[k] && out_ready_s[k]);
  endfunction

  // Model: an accepted pair produces a*b after WB cycles; result held until taken.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k] = 0; m_have[k] = 1'b0; m_ydef[k] = 1'b1; m_y[k] = 0;
      end else if (in_valid_s[k] && exp_ready(k)) begin
        m_have[k] = 1'b0; m_left[k] = WBV[k]; m_pend[k] = prod(k); m_ydef[k] = 1'b0;
      end else if (m_left[k] != 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_have[k] = 1'b1; m_y[k] = m_pend[k]; m_ydef[k] = 1'b1;
        end
      end else if (m_have[k] && out_ready_s[k]) begin
        m_have[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, want %0d (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst_n) chk("in_ready", k, ir_s[k], exp_ready(k));
      chk("out_valid", k, ov_s[k], m_have[k]);
      chk("busy", k, bz_s[k], m_left[k] != 0);
      if (m_ydef[k]) chk("y", k, y_x[k], m_y[k]);
      if (rst_n && ov_s[k] && !ov_prev[k] && acc_seen[k])
        chk("latency", k, cyc - acc_cyc[k], LAT[k]);
      if (rst_n && ov_s[k] && out_ready_s[k]) begin
        $display("txn[%0d] y=%0d at cycle %0d", k, y_x[k], cyc);
        if (k == 0 && lit_q.size() > 0) chk("literal", k, y_x[k], lit_q.pop_front());
      end
      if (rst_n && in_valid_s[k] && exp_ready(k)) begin
        acc_cyc[k] = cyc; acc_seen[k] = 1'b1;
      end
      ov_prev[k] = ov_s[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input int k);
    int t;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ir_s[k] === 1'b1) break;
    end
    if (t == 40) begin
      $display("FAIL accept_timeout[%0d]: no in_ready within 40 cycles", k);
      $fatal(1, "accept timeout");
    end
    tick();
  endtask

  task automatic wait_ov(input int k);
    int t;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ov_s[k] === 1'b1) break;
    end
    if (t == 40) begin
      $display("FAIL result_timeout[%0d]: no out_valid within 40 cycles", k);
      $fatal(1, "result timeout");
    end
    tick();
  endtask

  // One op on instance 0; while stalled, in_valid pulses with junk operands.
  task automatic op0(input int av, input int bv, input int stall);
    lit_q.push_back(longint'(av * bv));
    a0 = 8'(av); b0 = 8'(bv); in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b0;
    wait_accept(0);
    in_valid_s[0] = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
    wait_ov(0);
    for (int s = 0; s < stall; s++) begin
      in_valid_s[0] = s[0]; a0 = 8'($urandom); b0 = 8'($urandom);
      tick();
    end
    in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b1;
    tick();
    out_ready_s[0] = 1'b0;
  endtask

  int ca [6] = '{-128, -128, 127, -1,   0, 127};
  int cb [6] = '{  10, -128,  -1, -1, -77, 127};

  initial begin
    in_valid_s[0] = 1'b0; in_valid_s[1] = 1'b0;
    out_ready_s[0] = 1'b0; out_ready_s[1] = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) op0(ca[i], cb[i], 0);
    op0(45, -3, 5);

    // Back-to-back: in_valid held with the second pair while the first completes.
    lit_q.push_back(-300);
    lit_q.push_back(-3850);
    a0 = 8'(100); b0 = 8'(-3); in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b1;
    wait_accept(0);
    a0 = 8'(-50); b0 = 8'(77);
    wait_accept(0);
    in_valid_s[0] = 1'b0;
    wait_ov(0);
    out_ready_s[0] = 1'b0;

    // Abort mid-run with reset, then a fresh op.
    a0 = 8'(7); b0 = 8'(9); in_valid_s[0] = 1'b1;
    wait_accept(0);
    in_valid_s[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    op0(3, -5, 0);

    for (int c = 0; c < 20000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid_s[k]  = ($urandom_range(0, 3) != 0);
        out_ready_s[k] = ($urandom_range(0, 3) != 0);
      end
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 12'($urandom); b1 = 5'($urandom);
      tick();
    end
    in_valid_s[0] = 1'b0; in_valid_s[1] = 1'b0;
    out_ready_s[0] = 1'b1; out_ready_s[1] = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
